// File: rtl/rtable_arb_pkg.sv
// Shared q-learning definitions: address layout, action encodings, rewards, counter width.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rtable_arb_pkg;

    // Lookup address layout: {row, col, action}
    localparam int ROW_W     = 3;
    localparam int COL_W     = 3;
    localparam int ACT_W     = 2;
    localparam int RT_ADDR_W = ROW_W + COL_W + ACT_W;

    // Statistics counter width
    localparam int CNT_W = 16;

    // Reward encoding as stored in the table
    localparam int REWARD_W = 8;
    localparam logic [REWARD_W-1:0] R_NONE = 8'h00;
    localparam logic [REWARD_W-1:0] R_WALL = 8'h01;  // -255 truncated to 8 bits
    localparam logic [REWARD_W-1:0] R_GOAL = 8'hFF;

    // Goal cell sits in the bottom-right corner of the 8x8 grid
    localparam logic [ROW_W-1:0] GOAL_ROW = 3'd7;
    localparam logic [COL_W-1:0] GOAL_COL = 3'd7;

    typedef enum logic [ACT_W-1:0] {
        ACT_LEFT  = 2'b00,
        ACT_UP    = 2'b01,
        ACT_RIGHT = 2'b10,
        ACT_DOWN  = 2'b11
    } action_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        action_e          act;
    } rt_addr_t;

    // Reward for taking action 'act' from cell (row, col). Stepping off the
    // grid hits a wall; stepping onto the goal cell earns the goal reward.
    // Row 0 is the top edge, so UP decrements the row.
    function automatic logic [REWARD_W-1:0] reward_of(input rt_addr_t a);
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        logic             off_grid;
        r        = a.row;
        c        = a.col;
        off_grid = 1'b0;
        case (a.act)
            ACT_LEFT: begin
                if (a.col == '0) off_grid = 1'b1;
                else             c = a.col - 1'b1;
            end
            ACT_UP: begin
                if (a.row == '0) off_grid = 1'b1;
                else             r = a.row - 1'b1;
            end
            ACT_RIGHT: begin
                if (a.col == '1) off_grid = 1'b1;
                else             c = a.col + 1'b1;
            end
            default: begin  // ACT_DOWN
                if (a.row == '1) off_grid = 1'b1;
                else             r = a.row + 1'b1;
            end
        endcase
        if (off_grid) begin
            return R_WALL;
        end
        if ((r == GOAL_ROW) && (c == GOAL_COL)) begin
            return R_GOAL;
        end
        return R_NONE;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/rtable_arb_rom.sv
// Reward-table ROM: registered read of the reward for {row, col, action}.
// Latency: 1 cycle from rd_en to rd_dat; rd_dat holds its value when rd_en is low.
// Backpressure: none; no reset, so rd_dat is meaningless until the first read.
//
// Ports: i_clk; rd_en read strobe; rd_addr lookup address; rd_dat reward.
module rtable_arb_rom
    import rtable_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    if (ADDR_WIDTH != RT_ADDR_W) begin : g_addr_width_chk
        $error("rtable_arb_rom: ADDR_WIDTH must equal row+col+action width");
    end

    rt_addr_t rd_addr_s;
    assign rd_addr_s = rt_addr_t'(rd_addr);

    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rd_dat <= DATA_WIDTH'(reward_of(rd_addr_s));
        end
    end

endmodule

// File: rtl/rtable_arb.sv
// Round-robin arbiter sharing one reward-table ROM among NREQ lookup requesters.
// Latency: 1 cycle from handshake to one-hot response strobe; 1 lookup per cycle.
// Backpressure: per-requester ready = one-hot grant; responses cannot be stalled.
//
// Ports: i_clk, i_rst_n (sync, active-low); i_req_valid/i_req_addr per requester
// (requester k at i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH]); o_req_ready one-hot
// grant; o_rsp_valid one-hot strobe with o_rsp_data; o_lookup_cnt/o_nonzero_cnt
// saturating completed-lookup statistics.
module rtable_arb
    import rtable_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] i_req_addr,
    output logic [NREQ-1:0]            o_req_ready,
    output logic [NREQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]      o_rsp_data,
    output logic [CNT_W-1:0]           o_lookup_cnt,
    output logic [CNT_W-1:0]           o_nonzero_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if ((NREQ < 2) || (NREQ > 4)) begin : g_nreq_chk
        $error("rtable_arb: NREQ must be in 2..4");
    end

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      last_grant_q;
    logic [NREQ-1:0]       grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] tbl_addr;

    // Candidate requester at search offset 'off' after the last winner
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] last,
                                                input int               off);
        int s;
        s = int'(last) + 1 + off;
        return IDX_W'(s % NREQ);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && i_req_valid[rr_idx(last_grant_q, i)]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx(last_grant_q, i);
            end
        end
        // No grant may be offered while reset is being applied
        if (!i_rst_n) begin
            grant_any = 1'b0;
        end
        grant[grant_idx] = grant_any;
    end

    assign o_req_ready = grant;
    assign tbl_addr    = i_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // ------------------------------------------------------------------
    // Shared reward table
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rom_dat;

    rtable_arb_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rtable (
        .i_clk   (i_clk),
        .rd_en   (grant_any),
        .rd_addr (tbl_addr),
        .rd_dat  (rom_dat)
    );

    // ------------------------------------------------------------------
    // Response and statistics
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  rsp_sel_q;
    logic             rsp_any;
    logic [CNT_W-1:0] lookup_cnt_q;
    logic [CNT_W-1:0] nonzero_cnt_q;
    logic [CNT_W-1:0] lookup_cnt_nxt;
    logic [CNT_W-1:0] nonzero_cnt_nxt;

    // rsp_sel_q records who was granted last cycle, i.e. whose ROM read is
    // now on rom_dat. Gating with i_rst_n drops a lookup that was in flight
    // when reset arrived, so the reset cycle never carries a strobe.
    assign o_rsp_valid = rsp_sel_q & {NREQ{i_rst_n}};
    assign rsp_any     = |o_rsp_valid;

    // The ROM is unresetted and holds stale data between reads; only expose it
    // alongside a strobe.
    assign o_rsp_data = rsp_any ? rom_dat : '0;

    // Counters already include the response being strobed this cycle
    assign lookup_cnt_nxt  = sat_inc(lookup_cnt_q, rsp_any);
    assign nonzero_cnt_nxt = sat_inc(nonzero_cnt_q, rsp_any && (o_rsp_data != '0));
    assign o_lookup_cnt    = lookup_cnt_nxt;
    assign o_nonzero_cnt   = nonzero_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant_q  <= IDX_W'(NREQ - 1);  // requester 0 searched first
            rsp_sel_q     <= '0;
            lookup_cnt_q  <= '0;
            nonzero_cnt_q <= '0;
        end else begin
            if (grant_any) begin
                last_grant_q <= grant_idx;
            end
            rsp_sel_q     <= grant;
            lookup_cnt_q  <= lookup_cnt_nxt;
            nonzero_cnt_q <= nonzero_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_grant_onehot : assert property (@(posedge i_clk) $onehot0(o_req_ready));
    a_rsp_onehot   : assert property (@(posedge i_clk) $onehot0(o_rsp_valid));

endmodule

// File: tb/tb_rtable_arb.sv
module tb_rtable_arb;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;

    localparam logic [7:0] A_WALL = 8'b000_000_01;  // row0 up    -> 8'h01
    localparam logic [7:0] A_GOAL = 8'b110_111_11;  // (6,7) down -> 8'hFF
    localparam logic [7:0] A_ZERO = 8'b011_011_00;  // (3,3) left -> 8'h00

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ-1:0]      o_rsp_valid;
    logic [DW-1:0]        o_rsp_data;
    logic [15:0]          o_lookup_cnt;
    logic [15:0]          o_nonzero_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rtable_arb #(
        .NREQ       (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .o_req_ready   (o_req_ready),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_lookup_cnt  (o_lookup_cnt),
        .o_nonzero_cnt (o_nonzero_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        repeat (2) next_cycle();
        i_rst_n = 1'b1;
    endtask

    // Contention table: cycle-by-cycle expectations, req0 -> A_ZERO, req1 -> A_GOAL
    logic [1:0]  c_rdy [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0]  c_rsp [7] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0]  c_dat [7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [15:0] c_cnt [7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    logic [15:0] c_nz  [7] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_addr  = '0;

        // ---------------- reset state, requests ignored ----------------
        next_cycle();
        i_req_valid = 2'b11;
        i_req_addr  = {A_GOAL, A_WALL};
        @(negedge i_clk);
        check_val("rst_ready", 64'(o_req_ready), 64'(2'b00));
        check_val("rst_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'(0));
        next_cycle();
        @(negedge i_clk);
        check_val("rst_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'(0));
        i_req_valid = '0;
        i_rst_n     = 1'b1;
        next_cycle();

        // ---------------- single lookup, requester 0 ----------------
        i_req_valid = 2'b01;
        i_req_addr  = {8'h00, A_WALL};
        @(negedge i_clk);
        check_val("single_ready", 64'(o_req_ready), 64'(2'b01));
        next_cycle();
        i_req_valid = '0;
        @(negedge i_clk);
        check_val("single_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'({2'b01, 8'h01}));
        check_val("single_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'({16'd1, 16'd1}));
        next_cycle();

        // ---------------- goal then zero lookup, requester 1 ----------------
        i_req_valid = 2'b10;
        i_req_addr  = {A_GOAL, 8'h00};
        @(negedge i_clk);
        check_val("goal_ready", 64'(o_req_ready), 64'(2'b10));
        next_cycle();
        i_req_addr = {A_ZERO, 8'h00};
        @(negedge i_clk);
        check_val("goal_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'({2'b10, 8'hFF}));
        check_val("goal_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'({16'd2, 16'd2}));
        check_val("lone_ready", 64'(o_req_ready), 64'(2'b10));
        next_cycle();
        i_req_valid = '0;
        @(negedge i_clk);
        check_val("zero_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'({2'b10, 8'h00}));
        check_val("zero_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'({16'd3, 16'd2}));
        next_cycle();

        // ---------------- idle for 10 cycles ----------------
        i_req_addr = {A_GOAL, A_WALL};
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check_val($sformatf("idle_%0d", i),
                      64'({o_req_ready, o_rsp_valid, o_rsp_data, o_lookup_cnt, o_nonzero_cnt}),
                      64'({2'b00, 2'b00, 8'h00, 16'd3, 16'd2}));
            next_cycle();
        end

        // ---------------- contention: both valid for 6 cycles ----------------
        apply_reset();
        i_req_addr = {A_GOAL, A_ZERO};
        for (int i = 0; i < 7; i++) begin
            i_req_valid = (i < 6) ? 2'b11 : 2'b00;
            @(negedge i_clk);
            check_val($sformatf("cont_%0d", i),
                      64'({o_req_ready, o_rsp_valid, o_rsp_data, o_lookup_cnt, o_nonzero_cnt}),
                      64'({c_rdy[i], c_rsp[i], c_dat[i], c_cnt[i], c_nz[i]}));
            next_cycle();
        end

        // ---------------- reset while a lookup is in flight ----------------
        i_req_valid = 2'b01;
        i_req_addr  = {A_GOAL, A_WALL};
        @(negedge i_clk);
        check_val("mid_hs_ready", 64'(o_req_ready), 64'(2'b01));
        next_cycle();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        @(negedge i_clk);
        check_val("mid_rst_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'(0));
        next_cycle();
        i_rst_n     = 1'b1;
        i_req_valid = 2'b11;
        @(negedge i_clk);
        check_val("mid_after_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'(0));
        check_val("mid_after_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'(0));
        check_val("mid_first_grant", 64'(o_req_ready), 64'(2'b01));
        next_cycle();
        i_req_valid = '0;
        @(negedge i_clk);
        check_val("mid_first_rsp", 64'({o_rsp_valid, o_rsp_data}), 64'({2'b01, 8'h01}));
        check_val("mid_first_cnt", 64'({o_lookup_cnt, o_nonzero_cnt}), 64'({16'd1, 16'd1}));
        next_cycle();

        // ---------------- counter saturation ----------------
        apply_reset();
        i_req_addr = {A_WALL, A_WALL};
        for (int i = 0; i < 65539; i++) begin
            logic [15:0] e;
            i_req_valid = (i < 65537) ? 2'b11 : 2'b00;
            @(negedge i_clk);
            if (i >= 65533) begin
                e = (i >= 65535) ? 16'hFFFF : 16'(i);
                check_val($sformatf("sat_%0d", i),
                          64'({o_lookup_cnt, o_nonzero_cnt}), 64'({e, e}));
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
